bcd_mod_counter: RTL and testbench

Parametrised two-digit BCD modulo counter for the alarm-clock timekeeping chain, and the successor to the fixed mod-60 seconds counter. One instance covers seconds or minutes (0–59), 24-hour hours (0–23) or 12-hour hours (1–12) through parameters alone. It adds up/down counting, synchronous preset load with range checking, a borrow output alongside carry, and a compare output for alarm matching. Instances cascade by feeding one stage's `carry` or `borrow` into the next stage's `pulse`.

---
 rtl/bcd_mod_counter_if.sv | 27 ++
 rtl/bcd_mod_counter.sv | 137 +++++++++++++
 tb/tb_bcd_mod_counter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/bcd_mod_counter_if.sv
// Control, preset, compare and result signals of one BCD modulo counter stage.
// The master side (driver/testbench or upstream logic) drives controls; the counter is the slave.
interface bcd_mod_counter_if;
   logic       pulse;
   logic       down;
   logic       load;
   logic [3:0] load_tens;
   logic [3:0] load_ones;
   logic [3:0] cmp_tens;
   logic [3:0] cmp_ones;
   logic [3:0] tens;
   logic [3:0] ones;
   logic       carry;
   logic       borrow;
   logic       load_err;
   logic       match;

   modport master (
      output pulse, down, load, load_tens, load_ones, cmp_tens, cmp_ones,
      input  tens, ones, carry, borrow, load_err, match
   );

   modport slave (
      input  pulse, down, load, load_tens, load_ones, cmp_tens, cmp_ones,
      output tens, ones, carry, borrow, load_err, match
   );
endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD up/down modulo counter with range-checked preset, carry/borrow and compare.
// All count arithmetic is digit-wise BCD; MIN/MAX digits are fixed at elaboration.
module bcd_mod_counter #(
   parameter int MIN_VALUE = 0,
   parameter int MAX_VALUE = 59
) (
   input  logic               clk,
   input  logic               rst,
   bcd_mod_counter_if.slave   bus
);

   localparam logic [3:0] MIN_TENS = 4'(MIN_VALUE / 10);
   localparam logic [3:0] MIN_ONES = 4'(MIN_VALUE % 10);
   localparam logic [3:0] MAX_TENS = 4'(MAX_VALUE / 10);
   localparam logic [3:0] MAX_ONES = 4'(MAX_VALUE % 10);
   localparam logic [7:0] MIN_BCD  = {MIN_TENS, MIN_ONES};
   localparam logic [7:0] MAX_BCD  = {MAX_TENS, MAX_ONES};

   typedef enum logic [1:0] {
      OP_HOLD,
      OP_LOAD,
      OP_UP,
      OP_DOWN
   } op_e;

   logic [3:0] r_tens;
   logic [3:0] r_ones;
   logic       r_carry;
   logic       r_borrow;
   logic       r_load_err;

   op_e        w_op;
   logic [3:0] w_tens_nxt;
   logic [3:0] w_ones_nxt;
   logic       w_carry_nxt;
   logic       w_borrow_nxt;
   logic       w_load_err_nxt;
   logic       w_load_ok;
   logic       w_cur_ok;
   logic       w_at_min;
   logic       w_at_max;

   // With both digits <= 9, comparing the packed BCD byte orders values numerically.
   function automatic logic bcd_in_range(input logic [3:0] t, input logic [3:0] o);
      return (t <= 4'd9) && (o <= 4'd9) && ({t, o} >= MIN_BCD) && ({t, o} <= MAX_BCD);
   endfunction

   assign w_load_ok = bcd_in_range(bus.load_tens, bus.load_ones);
   assign w_cur_ok  = bcd_in_range(r_tens, r_ones);
   assign w_at_min  = ({r_tens, r_ones} == MIN_BCD);
   assign w_at_max  = ({r_tens, r_ones} == MAX_BCD);

   always_comb begin
      w_op = OP_HOLD;
      if (bus.load) begin
         w_op = OP_LOAD;
      end else if (bus.pulse) begin
         w_op = bus.down ? OP_DOWN : OP_UP;
      end
   end

   always_comb begin
      w_tens_nxt     = r_tens;
      w_ones_nxt     = r_ones;
      w_carry_nxt    = 1'b0;
      w_borrow_nxt   = 1'b0;
      w_load_err_nxt = 1'b0;
      case (w_op)
         OP_LOAD: begin
            if (w_load_ok) begin
               w_tens_nxt = bus.load_tens;
               w_ones_nxt = bus.load_ones;
            end else begin
               w_load_err_nxt = 1'b1;
            end
         end
         OP_UP: begin
            // An out-of-range count (unreachable in normal operation) recovers to MIN.
            if (!w_cur_ok) begin
               w_tens_nxt = MIN_TENS;
               w_ones_nxt = MIN_ONES;
            end else if (w_at_max) begin
               w_tens_nxt  = MIN_TENS;
               w_ones_nxt  = MIN_ONES;
               w_carry_nxt = 1'b1;
            end else if (r_ones == 4'd9) begin
               w_ones_nxt = 4'd0;
               w_tens_nxt = r_tens + 4'd1;
            end else begin
               w_ones_nxt = r_ones + 4'd1;
            end
         end
         OP_DOWN: begin
            if (!w_cur_ok) begin
               w_tens_nxt = MIN_TENS;
               w_ones_nxt = MIN_ONES;
            end else if (w_at_min) begin
               w_tens_nxt   = MAX_TENS;
               w_ones_nxt   = MAX_ONES;
               w_borrow_nxt = 1'b1;
            end else if (r_ones == 4'd0) begin
               w_ones_nxt = 4'd9;
               w_tens_nxt = r_tens - 4'd1;
            end else begin
               w_ones_nxt = r_ones - 4'd1;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tens     <= MIN_TENS;
         r_ones     <= MIN_ONES;
         r_carry    <= 1'b0;
         r_borrow   <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_tens     <= w_tens_nxt;
         r_ones     <= w_ones_nxt;
         r_carry    <= w_carry_nxt;
         r_borrow   <= w_borrow_nxt;
         r_load_err <= w_load_err_nxt;
      end
   end

   assign bus.tens     = r_tens;
   assign bus.ones     = r_ones;
   assign bus.carry    = r_carry;
   assign bus.borrow   = r_borrow;
   assign bus.load_err = r_load_err;
   // Zero-latency compare; consumers register it if they need a clean edge.
   assign bus.match    = ({r_tens, r_ones} == {bus.cmp_tens, bus.cmp_ones});

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for three counter stages (mod-60, hour12, hour24): directed scenarios plus random traffic,
// each cycle's expected outputs queued by an integer reference model and checked by a monitor.
module tb_bcd_mod_counter;

   logic clk;
   logic rst0, rst1, rst2;

   bcd_mod_counter_if b0 ();
   bcd_mod_counter_if b1 ();
   bcd_mod_counter_if b2 ();

   bcd_mod_counter #(.MIN_VALUE(0), .MAX_VALUE(59)) u_sec (.clk(clk), .rst(rst0), .bus(b0));
   bcd_mod_counter #(.MIN_VALUE(1), .MAX_VALUE(12)) u_h12 (.clk(clk), .rst(rst1), .bus(b1));
   bcd_mod_counter #(.MIN_VALUE(0), .MAX_VALUE(23)) u_h24 (.clk(clk), .rst(rst2), .bus(b2));

   // Expected word: {tens, ones, carry, borrow, load_err, match}
   logic [11:0] exp_q0[$];
   logic [11:0] exp_q1[$];
   logic [11:0] exp_q2[$];

   int n_checks = 0;
   int n_fail   = 0;

   int m_val[3];
   int m_min[3] = '{0, 1, 0};
   int m_max[3] = '{59, 12, 23};

   bit win = 0;
   int win_cyc = 0;
   int carry_pos[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t: got t/o=%0h/%0h c=%b b=%b e=%b m=%b, want t/o=%0h/%0h c=%b b=%b e=%b m=%b",
                  nm, $time, act[11:8], act[7:4], act[3], act[2], act[1], act[0],
                  exp[11:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic check_int(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   // Reference model: plain integer counting within [min, max].
   function automatic logic [11:0] model_step(input int idx, input bit r, input bit l, input bit p,
                                              input bit d, input int lt, input int lo,
                                              input logic [3:0] ct, input logic [3:0] co);
      bit c = 0, b = 0, e = 0;
      int v;
      logic [3:0] t4, o4;
      if (r) begin
         m_val[idx] = m_min[idx];
      end else if (l) begin
         v = 10 * lt + lo;
         if (lt <= 9 && lo <= 9 && v >= m_min[idx] && v <= m_max[idx]) m_val[idx] = v;
         else e = 1;
      end else if (p) begin
         if (d) begin
            if (m_val[idx] == m_min[idx]) begin m_val[idx] = m_max[idx]; b = 1; end
            else m_val[idx] = m_val[idx] - 1;
         end else begin
            if (m_val[idx] == m_max[idx]) begin m_val[idx] = m_min[idx]; c = 1; end
            else m_val[idx] = m_val[idx] + 1;
         end
      end
      t4 = 4'(m_val[idx] / 10);
      o4 = 4'(m_val[idx] % 10);
      return {t4, o4, c, b, e, ({t4, o4} == {ct, co})};
   endfunction

   task automatic idle_all();
      rst0 = 0; rst1 = 0; rst2 = 0;
      b0.load = 0; b0.pulse = 0; b0.down = 0;
      b1.load = 0; b1.pulse = 0; b1.down = 0;
      b2.load = 0; b2.pulse = 0; b2.down = 0;
   endtask

   task automatic drive(input int idx, input bit r, input bit l, input bit p, input bit d,
                        input logic [3:0] lt, input logic [3:0] lo,
                        input logic [3:0] ct, input logic [3:0] co);
      logic [11:0] e;
      @(negedge clk);
      idle_all();
      case (idx)
         0: begin rst0 = r; b0.load = l; b0.pulse = p; b0.down = d;
                  b0.load_tens = lt; b0.load_ones = lo; b0.cmp_tens = ct; b0.cmp_ones = co; end
         1: begin rst1 = r; b1.load = l; b1.pulse = p; b1.down = d;
                  b1.load_tens = lt; b1.load_ones = lo; b1.cmp_tens = ct; b1.cmp_ones = co; end
         default: begin rst2 = r; b2.load = l; b2.pulse = p; b2.down = d;
                  b2.load_tens = lt; b2.load_ones = lo; b2.cmp_tens = ct; b2.cmp_ones = co; end
      endcase
      e = model_step(idx, r, l, p, d, int'(lt), int'(lo), ct, co);
      case (idx)
         0: exp_q0.push_back(e);
         1: exp_q1.push_back(e);
         default: exp_q2.push_back(e);
      endcase
   endtask

   task automatic rand_step(input int idx);
      bit r, l, p, d;
      logic [3:0] lt, lo, ct, co;
      r  = ($urandom_range(0, 49) == 0);
      l  = ($urandom_range(0, 7) == 0);
      p  = ($urandom_range(0, 3) != 0);
      d  = 1'($urandom_range(0, 1));
      lt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
      lo = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      ct = 4'($urandom_range(0, 5));
      co = 4'($urandom_range(0, 9));
      drive(idx, r, l, p, d, lt, lo, ct, co);
   endtask

   always @(posedge clk) begin
      logic [11:0] e;
      #1;
      if (exp_q0.size() != 0) begin
         e = exp_q0.pop_front();
         check("sec", {b0.tens, b0.ones, b0.carry, b0.borrow, b0.load_err, b0.match}, e);
         if (win) begin
            win_cyc++;
            if (b0.carry) carry_pos.push_back(win_cyc);
         end
      end
   end

   always @(posedge clk) begin
      logic [11:0] e;
      #1;
      if (exp_q1.size() != 0) begin
         e = exp_q1.pop_front();
         check("hour12", {b1.tens, b1.ones, b1.carry, b1.borrow, b1.load_err, b1.match}, e);
      end
   end

   always @(posedge clk) begin
      logic [11:0] e;
      #1;
      if (exp_q2.size() != 0) begin
         e = exp_q2.pop_front();
         check("hour24", {b2.tens, b2.ones, b2.carry, b2.borrow, b2.load_err, b2.match}, e);
      end
   end

   initial begin
      idle_all();
      rst0 = 1; rst1 = 1; rst2 = 1;
      b0.load_tens = 0; b0.load_ones = 0; b0.cmp_tens = 4; b0.cmp_ones = 5;
      b1.load_tens = 0; b1.load_ones = 0; b1.cmp_tens = 0; b1.cmp_ones = 0;
      b2.load_tens = 0; b2.load_ones = 0; b2.cmp_tens = 0; b2.cmp_ones = 0;

      // Default stage: 5 reset clocks then 130 held pulses, compare value 45.
      for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 0, 0, 0, 4, 5);
      @(posedge clk); #2;
      win = 1;
      for (int i = 0; i < 130; i++) drive(0, 0, 0, 1, 0, 0, 0, 4, 5);
      @(posedge clk); #2;
      win = 0;
      check_int("carry_count", carry_pos.size(), 2);
      if (carry_pos.size() >= 2) begin
         check_int("carry_first_clock", carry_pos[0], 60);
         check_int("carry_second_clock", carry_pos[1], 120);
      end

      // Down count: 10 -> 09, 00 -> 59 with borrow.
      drive(0, 0, 1, 0, 0, 1, 0, 4, 5);
      drive(0, 0, 0, 1, 1, 0, 0, 4, 5);
      drive(0, 0, 1, 0, 0, 0, 0, 4, 5);
      drive(0, 0, 0, 1, 1, 0, 0, 4, 5);
      // Priority: load beats pulse at 58; reset beats load and pulse.
      drive(0, 0, 1, 0, 0, 5, 8, 4, 5);
      drive(0, 0, 1, 1, 0, 3, 0, 4, 5);
      drive(0, 1, 1, 1, 0, 5, 0, 4, 5);
      for (int i = 0; i < 300; i++) rand_step(0);

      // Hour12: up through 12 -> 01 with carry, then down at 01 -> 12 with borrow.
      drive(1, 1, 0, 0, 0, 0, 0, 1, 2);
      for (int i = 0; i < 12; i++) drive(1, 0, 0, 1, 0, 0, 0, 1, 2);
      drive(1, 0, 0, 1, 1, 0, 0, 1, 2);
      drive(1, 0, 0, 0, 0, 0, 0, 1, 2);
      for (int i = 0; i < 200; i++) rand_step(1);

      // Hour24: load 23 then wrap; rejected loads 24 and 0/A.
      drive(2, 1, 0, 0, 0, 0, 0, 0, 0);
      drive(2, 0, 1, 0, 0, 2, 3, 0, 0);
      drive(2, 0, 0, 1, 0, 0, 0, 0, 0);
      drive(2, 0, 1, 0, 0, 2, 4, 0, 0);
      drive(2, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(2, 0, 1, 0, 0, 0, 4'hA, 0, 0);
      drive(2, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 200; i++) rand_step(2);

      @(posedge clk); #2;
      @(posedge clk); #2;
      check_int("sec_queue_drained", exp_q0.size(), 0);
      check_int("hour12_queue_drained", exp_q1.size(), 0);
      check_int("hour24_queue_drained", exp_q2.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
